serial_adder_seq: RTL



---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_seq_if.sv | 25 ++
 rtl/serial_adder_seq_half_adder_cell.sv | 12 +
 rtl/serial_adder_seq.sv | 131 +++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int WIDTH_MAX = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_seq_if.sv
// Operand/result handshake bundle between a host sequencer and the serial adder.
interface serial_adder_seq_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, busy
  );

endinterface : serial_adder_seq_if

// File: rtl/serial_adder_seq_half_adder_cell.sv
// Single half-adder cell; two of them plus an OR form one full-add step.
module half_adder_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule : half_adder_cell

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one sum bit per clock, LSB first, WIDTH+1-bit result with
// valid/ready handshakes on both the operand and the result side.
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_adder_seq_if.slave        bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_bits_q, sum_bits_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_ready_c;
  logic             out_valid_c;
  logic             busy_c;

  logic             s1, c1, s2, c2;
  logic             fa_cout;

  half_adder_cell u_ha_ab (
    .x (a_q[0]),
    .y (b_q[0]),
    .s (s1),
    .c (c1)
  );

  half_adder_cell u_ha_cin (
    .x (s1),
    .y (carry_q),
    .s (s2),
    .c (c2)
  );

  // Both half-adder carries can never be set together, so OR is exact.
  assign fa_cout = c1 | c2;

  // NOTE: every _d and output gets its default before the case, so no latch
  // can be inferred for a path that does not assign it.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_bits_d  = sum_bits_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    cnt_d       = cnt_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Gating with rst keeps the source from seeing a handshake that the
        // reset branch of the register process would discard anyway.
        in_ready_c = !rst;
        if (bus.in_valid && !rst) begin
          a_d        = bus.a;
          b_d        = bus.b;
          sum_bits_d = '0;
          carry_d    = 1'b0;
          cout_d     = 1'b0;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        busy_c     = !rst;
        sum_bits_d = {s2, sum_bits_q[WIDTH-1:1]};
        a_d        = a_q >> 1;
        b_d        = b_q >> 1;
        carry_d    = fa_cout;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid_c = !rst;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_bits_q <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_bits_q <= sum_bits_d;
      carry_q    <= carry_d;
      cout_q     <= cout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.sum       = {cout_q, sum_bits_q};

endmodule : serial_adder_seq
